systolic_array_nxn: RTL and testbench

- Parametrised N×N output-stationary systolic matrix multiplier; successor to the fixed 2×2 array.
- Computes C = A·B with A N×K and B K×N; K is set at runtime per job.
- Owns its own input skewing, valid/ready input handshake, job FSM (IDLE/LOAD/FLUSH/DONE) and an indexed result read port.
- Sits between the operand-streaming front end and the result readout logic.

---
 rtl/systolic_array_nxn_pkg.sv | 25 ++
 rtl/systolic_array_nxn_pe_mac.sv | 44 ++++
 rtl/systolic_array_nxn.sv | 177 +++++++++++++++++
 tb/tb_systolic_array_nxn.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_nxn_pkg.sv
// rtl/systolic_array_nxn_pkg.sv - shared types and helpers for the NxN systolic multiplier
package systolic_array_nxn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Returns at least 1 so single-entry selects still get a legal port width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int acc_w_default(input int width, input int k_w);
    return 2 * width + k_w;
  endfunction

endpackage

// File: rtl/systolic_array_nxn_pe_mac.sv
// rtl/systolic_array_nxn_pe_mac.sv - one processing element: a/b pass-through and clearable MAC
module systolic_array_nxn_pe_mac #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [ACC_W-1:0] acc
);

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] prod;

  // The product uses the registered operands, so it lines up with the values passed on.
  always_comb begin
    a_d   = a_in;
    b_d   = b_in;
    prod  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    acc_d = clear ? '0 : acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_nxn.sv
// rtl/systolic_array_nxn.sv - NxN output-stationary systolic multiplier with job FSM and read port
module systolic_array_nxn
  import systolic_array_nxn_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int K_W   = 8,
  parameter int ACC_W = acc_w_default(WIDTH, K_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_W-1:0]        k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*WIDTH-1:0]    a_col,
  input  logic [N*WIDTH-1:0]    b_row,
  output logic                  busy,
  output logic                  done,
  input  logic [clog2(N)-1:0]   rd_row,
  input  logic [clog2(N)-1:0]   rd_col,
  output logic [ACC_W-1:0]      rd_data
);

  localparam int FL_W = clog2(2 * N);

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d, beat_cnt_q, beat_cnt_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             clear, accept;

  logic [WIDTH-1:0] a_gated [N];
  logic [WIDTH-1:0] b_gated [N];
  logic [WIDTH-1:0] a_edge  [N];
  logic [WIDTH-1:0] b_edge  [N];
  logic [WIDTH-1:0] a_pipe  [N][N];
  logic [WIDTH-1:0] b_pipe  [N][N];
  logic [ACC_W-1:0] acc_arr [N][N];
  logic             unused_tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    clear       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear       = 1'b1;
          k_d         = k_len;
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          state_d     = (k_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + K_W'(1);
          if (beat_cnt_q == k_q - K_W'(1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Drain until the last beat has reached the far corner PE.
        if (flush_cnt_q == FL_W'(2 * N - 2)) state_d = ST_DONE;
        else flush_cnt_d = flush_cnt_q + FL_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_LOAD);
    busy     = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    done     = (state_q == ST_DONE);
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_gated[i] = accept ? a_col[i*WIDTH +: WIDTH] : '0;
      b_gated[i] = accept ? b_row[i*WIDTH +: WIDTH] : '0;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_skew
    if (g == 0) begin : g_direct
      assign a_edge[g] = a_gated[g];
      assign b_edge[g] = b_gated[g];
    end else begin : g_delay
      logic [WIDTH-1:0] a_sh_q [g];
      logic [WIDTH-1:0] a_sh_d [g];
      logic [WIDTH-1:0] b_sh_q [g];
      logic [WIDTH-1:0] b_sh_d [g];

      always_comb begin
        a_sh_d[0] = a_gated[g];
        b_sh_d[0] = b_gated[g];
        for (int s = 1; s < g; s++) begin
          a_sh_d[s] = a_sh_q[s-1];
          b_sh_d[s] = b_sh_q[s-1];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < g; s++) begin
            a_sh_q[s] <= '0;
            b_sh_q[s] <= '0;
          end
        end else begin
          a_sh_q <= a_sh_d;
          b_sh_q <= b_sh_d;
        end
      end

      assign a_edge[g] = a_sh_q[g-1];
      assign b_edge[g] = b_sh_q[g-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [WIDTH-1:0] a_src, b_src;
      if (j == 0) begin : g_a_edge
        assign a_src = a_edge[i];
      end else begin : g_a_left
        assign a_src = a_pipe[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_src = b_edge[j];
      end else begin : g_b_up
        assign b_src = b_pipe[i-1][j];
      end

      systolic_array_nxn_pe_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a_in  (a_src),
        .b_in  (b_src),
        .a_out (a_pipe[i][j]),
        .b_out (b_pipe[i][j]),
        .acc   (acc_arr[i][j])
      );
    end
  end

  // Operands leaving the last column/row have nowhere to go.
  always_comb begin
    unused_tail = 1'b0;
    for (int i = 0; i < N; i++) begin
      unused_tail = unused_tail ^ (^a_pipe[i][N-1]) ^ (^b_pipe[N-1][i]);
    end
  end

  assign rd_data = acc_arr[rd_row][rd_col];

endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb/tb_systolic_array_nxn.sv - directed self-checking bench for systolic_array_nxn
module tb_systolic_array_nxn;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        s4_start = 0, s4_valid = 0, s4_ready, s4_busy, s4_done;
  logic [7:0]  s4_k = 0;
  logic [31:0] s4_a = 0, s4_b = 0;
  logic [1:0]  s4_row = 0, s4_col = 0;
  logic [23:0] s4_rd;

  logic        s2_start = 0, s2_valid = 0, s2_ready, s2_busy, s2_done;
  logic [7:0]  s2_k = 0;
  logic [15:0] s2_a = 0, s2_b = 0;
  logic [0:0]  s2_row = 0, s2_col = 0;
  logic [23:0] s2_rd;

  logic        sw_start = 0, sw_valid = 0, sw_ready, sw_busy, sw_done;
  logic [7:0]  sw_k = 0;
  logic [15:0] sw_a = 0, sw_b = 0;
  logic [0:0]  sw_row = 0, sw_col = 0;
  logic [15:0] sw_rd;

  systolic_array_nxn #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4_start), .k_len(s4_k), .in_valid(s4_valid),
    .in_ready(s4_ready), .a_col(s4_a), .b_row(s4_b), .busy(s4_busy), .done(s4_done),
    .rd_row(s4_row), .rd_col(s4_col), .rd_data(s4_rd)
  );

  systolic_array_nxn #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .k_len(s2_k), .in_valid(s2_valid),
    .in_ready(s2_ready), .a_col(s2_a), .b_row(s2_b), .busy(s2_busy), .done(s2_done),
    .rd_row(s2_row), .rd_col(s2_col), .rd_data(s2_rd)
  );

  systolic_array_nxn #(.N(2), .ACC_W(16)) dutw (
    .clk(clk), .rst(rst), .start(sw_start), .k_len(sw_k), .in_valid(sw_valid),
    .in_ready(sw_ready), .a_col(sw_a), .b_row(sw_b), .busy(sw_busy), .done(sw_done),
    .rd_row(sw_row), .rd_col(sw_col), .rd_data(sw_rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({s4_ready, s4_busy, s4_done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000", {s4_ready, s4_busy, s4_done});
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s4_row = 2'(i); s4_col = 2'(j); #1;
        total++;
        if (s4_rd !== 24'd0) begin
          bad++;
          $display("FAIL reset_rd[%0d][%0d] got=%0d want=0", i, j, s4_rd);
        end
      end
    end
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    int n;
    int exp_c[4];
    exp_c = '{1, 2, 3, 4};
    s2_k = 8'd2; s2_start = 1'b1; tick(); s2_start = 1'b0;
    total++;
    if (s2_ready !== 1'b1) begin
      bad++;
      $display("FAIL id_ready_load got=%b want=1", s2_ready);
    end
    s2_a = {8'd3, 8'd1}; s2_b = {8'd0, 8'd1}; s2_valid = 1'b1; tick();
    s2_a = {8'd4, 8'd2}; s2_b = {8'd1, 8'd0}; tick();
    s2_valid = 1'b0; s2_a = '0; s2_b = '0;
    total++;
    if ({s2_ready, s2_busy, s2_done} !== 3'b010) begin
      bad++;
      $display("FAIL id_flush_ctrl got=%b want=010", {s2_ready, s2_busy, s2_done});
    end
    n = 0;
    while (!s2_done && n < 50) begin tick(); n++; end
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL id_done_latency got=%0d want=3", n);
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s2_row = 1'(i); s2_col = 1'(j); #1;
        total++;
        if (s2_rd !== 24'(exp_c[i*2+j])) begin
          bad++;
          $display("FAIL id_c[%0d][%0d] got=%0d want=%0d", i, j, s2_rd, exp_c[i*2+j]);
        end
      end
    end
  endtask

  task automatic test_bubbles();
    int accepted, n, cyc;
    s4_k = 8'd4; s4_start = 1'b1; tick(); s4_start = 1'b0;
    s4_a = 32'hFFFF_FFFF; s4_b = 32'hFFFF_FFFF;
    accepted = 0; cyc = 0;
    while (accepted < 4 && cyc < 40) begin
      s4_valid = (cyc % 2 == 0);
      total++;
      if (s4_ready !== 1'b1 || s4_busy !== 1'b1) begin
        bad++;
        $display("FAIL bub_ready_load cyc=%0d got=%b%b want=11", cyc, s4_ready, s4_busy);
      end
      if (s4_ready && s4_valid) accepted++;
      tick();
      cyc++;
    end
    s4_valid = 1'b0; s4_a = '0; s4_b = '0;
    total++;
    if (accepted !== 4 || cyc !== 7) begin
      bad++;
      $display("FAIL bub_beats got=%0d/%0d want=4/7", accepted, cyc);
    end
    n = 0;
    while (!s4_done && n < 60) begin
      total++;
      if (s4_ready !== 1'b0) begin
        bad++;
        $display("FAIL bub_ready_flush got=%b want=0", s4_ready);
      end
      tick(); n++;
    end
    total++;
    if (n !== 7) begin
      bad++;
      $display("FAIL bub_done_latency got=%0d want=7", n);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s4_row = 2'(i); s4_col = 2'(j); #1;
        total++;
        if (s4_rd !== 24'd260100) begin
          bad++;
          $display("FAIL bub_c[%0d][%0d] got=%0d want=260100", i, j, s4_rd);
        end
      end
    end
  endtask

  task automatic test_zero_k();
    int n;
    s4_k = 8'd0; s4_start = 1'b1; tick(); s4_start = 1'b0;
    total++;
    if ({s4_ready, s4_busy, s4_done} !== 3'b001) begin
      bad++;
      $display("FAIL zk_ctrl got=%b want=001", {s4_ready, s4_busy, s4_done});
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s4_row = 2'(i); s4_col = 2'(j); #1;
        total++;
        if (s4_rd !== 24'd0) begin
          bad++;
          $display("FAIL zk_c[%0d][%0d] got=%0d want=0", i, j, s4_rd);
        end
      end
    end
    s4_k = 8'd1; s4_start = 1'b1; tick(); s4_start = 1'b0;
    total++;
    if ({s4_ready, s4_done} !== 2'b10) begin
      bad++;
      $display("FAIL zk_restart got=%b want=10", {s4_ready, s4_done});
    end
    s4_a = 32'h0202_0202; s4_b = 32'h0303_0303; s4_valid = 1'b1; tick();
    s4_valid = 1'b0; s4_a = '0; s4_b = '0;
    n = 0;
    while (!s4_done && n < 60) begin tick(); n++; end
    total++;
    if (n !== 7) begin
      bad++;
      $display("FAIL k1_done_latency got=%0d want=7", n);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s4_row = 2'(i); s4_col = 2'(j); #1;
        total++;
        if (s4_rd !== 24'd6) begin
          bad++;
          $display("FAIL k1_c[%0d][%0d] got=%0d want=6", i, j, s4_rd);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    sw_k = 8'd2; sw_start = 1'b1; tick(); sw_start = 1'b0;
    sw_a = 16'hFFFF; sw_b = 16'hFFFF; sw_valid = 1'b1; tick(); tick();
    sw_valid = 1'b0; sw_a = '0; sw_b = '0;
    n = 0;
    while (!sw_done && n < 50) begin tick(); n++; end
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL wrap_done_latency got=%0d want=3", n);
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        sw_row = 1'(i); sw_col = 1'(j); #1;
        total++;
        if (sw_rd !== 16'd64514) begin
          bad++;
          $display("FAIL wrap_c[%0d][%0d] got=%0d want=64514", i, j, sw_rd);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int n;
    int exp_c[4];
    exp_c = '{1, 2, 3, 4};
    s2_k = 8'd2; s2_start = 1'b1; tick();
    s2_k = 8'd0;
    s2_a = {8'd3, 8'd1}; s2_b = {8'd0, 8'd1}; s2_valid = 1'b1; tick();
    s2_start = 1'b0;
    s2_a = {8'd4, 8'd2}; s2_b = {8'd1, 8'd0}; tick();
    s2_valid = 1'b0; s2_a = '0; s2_b = '0;
    s2_start = 1'b1;
    total++;
    if ({s2_ready, s2_busy, s2_done} !== 3'b010) begin
      bad++;
      $display("FAIL ign_flush_ctrl got=%b want=010", {s2_ready, s2_busy, s2_done});
    end
    n = 0;
    while (!s2_done && n < 50) begin
      tick(); n++;
      if (n == 2) s2_start = 1'b0;
    end
    s2_start = 1'b0;
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL ign_done_latency got=%0d want=3", n);
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s2_row = 1'(i); s2_col = 1'(j); #1;
        total++;
        if (s2_rd !== 24'(exp_c[i*2+j])) begin
          bad++;
          $display("FAIL ign_c[%0d][%0d] got=%0d want=%0d", i, j, s2_rd, exp_c[i*2+j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    s4_k = 8'd4; s4_start = 1'b1; tick(); s4_start = 1'b0;
    s4_a = 32'h0102_0304; s4_b = 32'h0506_0708; s4_valid = 1'b1; tick(); tick();
    s4_valid = 1'b0; tick(); tick(); tick();
    s4_row = 2'd0; s4_col = 2'd0; #1;
    total++;
    if (s4_ready !== 1'b1 || s4_rd === 24'd0) begin
      bad++;
      $display("FAIL mid_precond got=ready%b rd%0d want=ready1 rd_nonzero", s4_ready, s4_rd);
    end
    rst = 1'b0; #1;
    total++;
    if ({s4_ready, s4_busy, s4_done} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset_ctrl got=%b want=000", {s4_ready, s4_busy, s4_done});
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s4_row = 2'(i); s4_col = 2'(j); #0.1;
        total++;
        if (s4_rd !== 24'd0) begin
          bad++;
          $display("FAIL mid_reset_rd[%0d][%0d] got=%0d want=0", i, j, s4_rd);
        end
      end
    end
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_bubbles();
    test_zero_k();
    test_wrap();
    test_start_ignored();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
